pc_sequencer: RTL and testbench

- Next-address controller for the 8-bit program counter register: computes its `d` input every cycle and drives its `clr`.
- Fetch/execute FSM with an instruction-memory handshake.
- Handles sequential, jump, conditional branch, call/return (internal return-address stack) and halt.
- Sits between the decode stage (command source) and the program counter; the PC register loads `pc_d` on every `clk` edge.

---
 rtl/pc_seq_pkg.sv | 30 +++
 rtl/ret_addr_stack.sv | 60 ++++++
 rtl/pc_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pc_seq_pkg : shared types for the program-counter sequencer
// Rev 1.0
// ============================================================================
package pc_seq_pkg;

    localparam int PC_AW = 8;

    typedef logic [PC_AW-1:0] addr_t;

    typedef enum logic [2:0] {
        CMD_SEQ    = 3'd0,
        CMD_JUMP   = 3'd1,
        CMD_BRANCH = 3'd2,
        CMD_CALL   = 3'd3,
        CMD_RET    = 3'd4,
        CMD_HALT   = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ret_addr_stack.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ret_addr_stack : DEPTH x AW LIFO of return addresses, async active-low reset
// Rev 1.0
// ============================================================================
module ret_addr_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_idx  = IW'(count_q);
    // top is only meaningful while the stack is non-empty
    assign top_idx = IW'(count_q - CW'(1));
    assign top     = mem_q[top_idx];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            count_d       = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pc_sequencer : next-address controller and fetch/exec FSM for the 8-bit PC.
// Optional interrupt entry enabled by macro PC_SEQ_IRQ_EN.   Rev 1.0
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int            AW        = 8,
    parameter int            RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter logic [AW-1:0] IRQ_VEC   = AW'(8'hF0)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] pc,
    input  logic          imem_ack,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd,
    input  logic          cond,
    input  logic [AW-1:0] target,
    input  logic          stall,
`ifdef PC_SEQ_IRQ_EN
    input  logic          irq,
    output logic          irq_ack,
`endif
    output logic [AW-1:0] pc_d,
    output logic          pc_clr,
    output logic          fetch_req,
    output logic          cmd_ready,
    output logic          halted,
    output logic          ras_ovf,
    output logic          ras_unf
);

    state_e        state_q, state_d;
    logic          ras_ovf_q, ras_ovf_d;
    logic          ras_unf_q, ras_unf_d;
    logic          push_req, push, pop;
    logic [AW-1:0] push_data, stack_top, pc_inc;
    logic          stack_full, stack_empty;
    logic          irq_take, cmd_accept;

    assign pc_inc     = pc + AW'(1);
    assign pc_clr     = ~clr;
    assign ras_ovf    = ras_ovf_q;
    assign ras_unf    = ras_unf_q;
    assign cmd_accept = (state_q == ST_EXEC) & cmd_valid & ~stall & ~irq_take;

`ifdef PC_SEQ_IRQ_EN
    logic in_isr_q, in_isr_d;
    logic ret_accept;

    assign irq_take   = irq & ~in_isr_q &
                        (((state_q == ST_EXEC) & ~stall) | (state_q == ST_HALT));
    assign ret_accept = cmd_accept & (cmd_e'(cmd) == CMD_RET);
    assign irq_ack    = irq_take;
    assign in_isr_d   = irq_take ? 1'b1 : (ret_accept ? 1'b0 : in_isr_q);
`else
    assign irq_take = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_RST;
            ras_ovf_q <= 1'b0;
            ras_unf_q <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
            in_isr_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ras_ovf_q <= ras_ovf_d;
            ras_unf_q <= ras_unf_d;
`ifdef PC_SEQ_IRQ_EN
            in_isr_q  <= in_isr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:   state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_EXEC;
            ST_EXEC: begin
                if (irq_take) begin
                    state_d = ST_FETCH;
                end else if (cmd_accept) begin
                    state_d = (cmd_e'(cmd) == CMD_HALT) ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:  if (irq_take) state_d = ST_FETCH;
            default:  state_d = ST_RST;
        endcase
    end

    always_comb begin
        pc_d      = pc;
        fetch_req = 1'b0;
        cmd_ready = 1'b0;
        halted    = 1'b0;
        push_req  = 1'b0;
        push_data = pc_inc;
        pop       = 1'b0;
        ras_ovf_d = ras_ovf_q;
        ras_unf_d = ras_unf_q;
        case (state_q)
            ST_RST:   pc_d = RESET_VEC;
            ST_FETCH: fetch_req = 1'b1;
            ST_EXEC: begin
                cmd_ready = ~stall & ~irq_take;
                // interrupt return address is the current pc so the pending command is replayed
                if (irq_take) begin
                    push_req  = 1'b1;
                    push_data = pc;
                    pc_d      = IRQ_VEC;
                end else if (cmd_accept) begin
                    case (cmd_e'(cmd))
                        CMD_JUMP:   pc_d = target;
                        CMD_BRANCH: pc_d = cond ? target : pc_inc;
                        CMD_CALL: begin
                            push_req = 1'b1;
                            pc_d     = target;
                        end
                        CMD_RET: begin
                            if (stack_empty) begin
                                ras_unf_d = 1'b1;
                                pc_d      = pc_inc;
                            end else begin
                                pop  = 1'b1;
                                pc_d = stack_top;
                            end
                        end
                        CMD_HALT:   pc_d = pc;
                        default:    pc_d = pc_inc;
                    endcase
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (irq_take) begin
                    push_req  = 1'b1;
                    push_data = pc;
                    pc_d      = IRQ_VEC;
                end
            end
            default:  pc_d = RESET_VEC;
        endcase
        push = push_req & ~stack_full;
        if (push_req && stack_full) ras_ovf_d = 1'b1;
    end

    ret_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .AW    (AW)
    ) u_ras (
        .clk       (clk),
        .rst_n     (clr),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_pc_sequencer : randomized self-checking bench with a queue-based model
// Rev 1.0
// ============================================================================
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int         RAS_DEPTH = 4;
    localparam logic [7:0] RESET_VEC = 8'h00;
    localparam logic [7:0] IRQ_VEC   = 8'hF0;

    logic       clk, clr, imem_ack, cmd_valid, cond, stall;
    logic [2:0] cmd;
    logic [7:0] target, pc, pc_d;
    logic       pc_clr, fetch_req, cmd_ready, halted, ras_ovf, ras_unf;
`ifdef PC_SEQ_IRQ_EN
    logic       irq, irq_ack;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] m_pc;
    logic [7:0] m_stack[$];
    logic       m_ovf, m_unf, m_halt;

    pc_sequencer #(
        .AW        (8),
        .RAS_DEPTH (RAS_DEPTH),
        .RESET_VEC (RESET_VEC),
        .IRQ_VEC   (IRQ_VEC)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .pc        (pc),
        .imem_ack  (imem_ack),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cond      (cond),
        .target    (target),
        .stall     (stall),
`ifdef PC_SEQ_IRQ_EN
        .irq       (irq),
        .irq_ack   (irq_ack),
`endif
        .pc_d      (pc_d),
        .pc_clr    (pc_clr),
        .fetch_req (fetch_req),
        .cmd_ready (cmd_ready),
        .halted    (halted),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the program counter register the sequencer drives
    always_ff @(posedge clk or posedge pc_clr) begin
        if (pc_clr) pc <= 8'h00;
        else        pc <= pc_d;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_pc = RESET_VEC;
        m_stack.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_halt = 1'b0;
    endfunction

    function automatic logic [7:0] model_exec(input logic [2:0] c, input logic cnd,
                                              input logic [7:0] tgt);
        logic [7:0] inc;
        logic [7:0] nxt;
        inc = m_pc + 8'd1;
        case (c)
            CMD_JUMP:   nxt = tgt;
            CMD_BRANCH: nxt = cnd ? tgt : inc;
            CMD_CALL: begin
                if (m_stack.size() < RAS_DEPTH) m_stack.push_back(inc);
                else                            m_ovf = 1'b1;
                nxt = tgt;
            end
            CMD_RET: begin
                if (m_stack.size() > 0) nxt = m_stack.pop_back();
                else begin
                    m_unf = 1'b1;
                    nxt   = inc;
                end
            end
            CMD_HALT: begin
                nxt    = m_pc;
                m_halt = 1'b1;
            end
            default:    nxt = inc;
        endcase
        m_pc = nxt;
        return nxt;
    endfunction

    task automatic wait_exec(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            imem_ack = (n >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_exec: cmd_ready never rose within 64 cycles");
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic cnd, input logic [7:0] tgt);
        bit         ok;
        int         ns;
        logic [7:0] exp;
        wait_exec(ok);
        if (!ok) return;
        ns = $urandom_range(0, 2);
        for (int i = 0; i < ns; i++) begin
            stall     = 1'b1;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd       = 3'($urandom_range(0, 7));
            target    = 8'($urandom);
            #1;
            n_checks++;
            if (cmd_ready !== 1'b0 || pc_d !== pc) begin
                n_fail++;
                $display("FAIL stall_hold: cmd_ready=%b pc_d=%h pc=%h, want 0 and pc_d==pc",
                         cmd_ready, pc_d, pc);
            end
            @(negedge clk);
        end
        stall     = 1'b0;
        cmd_valid = 1'b1;
        cmd       = c;
        cond      = cnd;
        target    = tgt;
        exp       = model_exec(c, cnd, tgt);
        #1;
        n_checks++;
        if (pc_d !== exp) begin
            n_fail++;
            $display("FAIL cmd_pc_d: cmd=%0d got %h expected %h", c, pc_d, exp);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 3'($urandom_range(0, 7));
        target    = 8'($urandom);
        cond      = 1'($urandom_range(0, 1));
        n_checks++;
        if (pc !== m_pc || ras_ovf !== m_ovf || ras_unf !== m_unf || halted !== m_halt) begin
            n_fail++;
            $display("FAIL after_cmd: pc=%h ovf=%b unf=%b halted=%b expected %h %b %b %b",
                     pc, ras_ovf, ras_unf, halted, m_pc, m_ovf, m_unf, m_halt);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr       = 1'b0;
        cmd_valid = 1'b0;
        stall     = 1'b0;
        imem_ack  = 1'b1;
`ifdef PC_SEQ_IRQ_EN
        irq       = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b0; cmd_valid = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        cmd = 3'd0; cond = 1'b0; target = 8'h00;
`ifdef PC_SEQ_IRQ_EN
        irq = 1'b0;
`endif
        model_reset();
        #22;
        n_checks++;
        if ({fetch_req, cmd_ready, halted, ras_ovf, ras_unf, pc_clr} !== 6'b000001 ||
            pc_d !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_outputs: flags=%b pc_d=%h expected 000001 %h",
                     {fetch_req, cmd_ready, halted, ras_ovf, ras_unf, pc_clr}, pc_d, RESET_VEC);
        end
        @(negedge clk);
        clr = 1'b1;
        #1;
        n_checks++;
        if (pc_clr !== 1'b0 || fetch_req !== 1'b0 || pc_d !== RESET_VEC) begin
            n_fail++;
            $display("FAIL rst_state: pc_clr=%b fetch_req=%b pc_d=%h expected 0 0 %h",
                     pc_clr, fetch_req, pc_d, RESET_VEC);
        end
        @(negedge clk);
        n_checks++;
        if (fetch_req !== 1'b1 || pc !== RESET_VEC) begin
            n_fail++;
            $display("FAIL first_fetch: fetch_req=%b pc=%h expected 1 %h", fetch_req, pc, RESET_VEC);
        end
    endtask

    task automatic test_seq();
        for (int i = 0; i < 3; i++) begin
            issue(CMD_SEQ, 1'b0, 8'h00);
            n_checks++;
            if (pc !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL seq_step: got %h expected %h", pc, 8'(i + 1));
            end
        end
    endtask

    task automatic test_wrap();
        issue(CMD_JUMP, 1'b0, 8'hFF);
        issue(CMD_SEQ, 1'b0, 8'h00);
        n_checks++;
        if (pc !== 8'h00 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: pc=%h ovf=%b unf=%b expected 00 0 0", pc, ras_ovf, ras_unf);
        end
    endtask

    task automatic test_branch();
        issue(CMD_JUMP, 1'b0, 8'h10);
        issue(CMD_BRANCH, 1'b0, 8'h40);
        n_checks++;
        if (pc !== 8'h11) begin
            n_fail++;
            $display("FAIL branch_not_taken: got %h expected 11", pc);
        end
        issue(CMD_BRANCH, 1'b1, 8'h40);
        n_checks++;
        if (pc !== 8'h40) begin
            n_fail++;
            $display("FAIL branch_taken: got %h expected 40", pc);
        end
    endtask

    task automatic test_stack();
        logic [7:0] ret_exp [4];
        ret_exp = '{8'h41, 8'h31, 8'h21, 8'h11};
        issue(CMD_JUMP, 1'b0, 8'h10);
        for (int i = 0; i < 5; i++) begin
            issue(CMD_CALL, 1'b0, 8'(8'h20 + 8'(i) * 8'h10));
            n_checks++;
            if (ras_ovf !== (i == 4)) begin
                n_fail++;
                $display("FAIL call_ovf_%0d: got %b expected %b", i, ras_ovf, (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            issue(CMD_RET, 1'b0, 8'h00);
            n_checks++;
            if (pc !== ret_exp[i] || ras_unf !== 1'b0) begin
                n_fail++;
                $display("FAIL ret_%0d: pc=%h unf=%b expected %h 0", i, pc, ras_unf, ret_exp[i]);
            end
        end
        issue(CMD_RET, 1'b0, 8'h00);
        n_checks++;
        if (pc !== 8'h12 || ras_unf !== 1'b1) begin
            n_fail++;
            $display("FAIL ret_underflow: pc=%h unf=%b expected 12 1", pc, ras_unf);
        end
    endtask

    task automatic test_fetch_reset();
        issue(CMD_JUMP, 1'b0, 8'h33);
        imem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fetch_req !== 1'b1 || pc_d !== 8'h33 || pc !== 8'h33) begin
            n_fail++;
            $display("FAIL fetch_hold: fetch_req=%b pc_d=%h pc=%h expected 1 33 33",
                     fetch_req, pc_d, pc);
        end
        #2;
        clr = 1'b0;
        #1;
        n_checks++;
        if ({fetch_req, cmd_ready, halted, ras_ovf, ras_unf, pc_clr} !== 6'b000001 ||
            pc_d !== RESET_VEC || pc !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: flags=%b pc_d=%h pc=%h expected 000001 00 00",
                     {fetch_req, cmd_ready, halted, ras_ovf, ras_unf, pc_clr}, pc_d, pc);
        end
        model_reset();
        @(negedge clk);
        clr      = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pc !== 8'h00 || fetch_req !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_pc: pc=%h fetch_req=%b expected 00 1", pc, fetch_req);
        end
    endtask

    task automatic test_halt();
        logic [7:0] frozen;
        issue(CMD_SEQ, 1'b0, 8'h00);
        issue(CMD_HALT, 1'b0, 8'h00);
        frozen = m_pc;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd       = 3'($urandom_range(0, 7));
            target    = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (pc !== frozen || halted !== 1'b1 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_frozen: pc=%h halted=%b cmd_ready=%b expected %h 1 0",
                         pc, halted, cmd_ready, frozen);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] c;
        for (int i = 0; i < 60; i++) begin
            do c = 3'($urandom_range(0, 7)); while (c == CMD_HALT);
            issue(c, 1'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

`ifdef PC_SEQ_IRQ_EN
    task automatic test_irq();
        bit ok;
        issue(CMD_JUMP, 1'b0, 8'h22);
        wait_exec(ok);
        cmd_valid = 1'b1;
        cmd       = CMD_JUMP;
        target    = 8'h55;
        irq       = 1'b1;
        #1;
        n_checks++;
        if (irq_ack !== 1'b1 || cmd_ready !== 1'b0 || pc_d !== IRQ_VEC) begin
            n_fail++;
            $display("FAIL irq_take: ack=%b ready=%b pc_d=%h expected 1 0 %h",
                     irq_ack, cmd_ready, pc_d, IRQ_VEC);
        end
        m_stack.push_back(8'h22);
        m_pc = IRQ_VEC;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (irq_ack !== 1'b0 || pc !== IRQ_VEC) begin
            n_fail++;
            $display("FAIL irq_pulse: ack=%b pc=%h expected 0 %h", irq_ack, pc, IRQ_VEC);
        end
        issue(CMD_SEQ, 1'b0, 8'h00);
        irq = 1'b0;
        issue(CMD_RET, 1'b0, 8'h00);
        n_checks++;
        if (pc !== 8'h22) begin
            n_fail++;
            $display("FAIL irq_return: got %h expected 22", pc);
        end
        issue(CMD_JUMP, 1'b0, 8'h55);
        n_checks++;
        if (pc !== 8'h55) begin
            n_fail++;
            $display("FAIL irq_replay: got %h expected 55", pc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_seq();
        test_wrap();
        test_branch();
        test_stack();
        test_fetch_reset();
        test_halt();
        do_reset();
        test_random();
`ifdef PC_SEQ_IRQ_EN
        do_reset();
        test_irq();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
